// File: rtl/blake2_block_packer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : blake2_block_packer_if
// Brief    : Message-stream and hash-engine command bundle for the packer.
// Revision : 1.0
// ============================================================================
interface blake2_block_packer_if #(
    parameter int BLOCK_WIDTH = 1024,
    parameter int DATA_LENGTH = 128,
    parameter int WORD_WIDTH  = 64
);
    localparam int c_NB = WORD_WIDTH / 8;

    logic [WORD_WIDTH-1:0]  in_data;
    logic                   in_valid;
    logic                   in_last;
    logic [$clog2(c_NB):0]  in_bytes;
    logic                   in_ready;
    logic                   hash_ready;
    logic                   digest_valid;
    logic                   init;
    logic                   next;
    logic                   final_cmd;
    logic [BLOCK_WIDTH-1:0] block_out;
    logic [DATA_LENGTH-1:0] data_length;
    logic                   msg_done;

    modport master (
        output in_data, in_valid, in_last, in_bytes, hash_ready, digest_valid,
        input  in_ready, init, next, final_cmd, block_out, data_length, msg_done
    );

    modport slave (
        input  in_data, in_valid, in_last, in_bytes, hash_ready, digest_valid,
        output in_ready, init, next, final_cmd, block_out, data_length, msg_done
    );
endinterface
`default_nettype wire

// File: rtl/blake2_block_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : blake2_block_packer
// Brief    : Packs 64-bit message words into zero-padded BLAKE2 blocks and
//            issues init/next/final commands with the cumulative byte count.
//            Optional macro PACKER_BYTE_SWAP_EN byte-reverses each input word.
// Revision : 1.0
// ============================================================================
module blake2_block_packer #(
    parameter int BLOCK_WIDTH = 1024,
    parameter int DATA_LENGTH = 128,
    parameter int WORD_WIDTH  = 64
) (
    input wire                 clk,
    input wire                 reset,
    blake2_block_packer_if.slave bus
);
    localparam int c_NW   = BLOCK_WIDTH / WORD_WIDTH;
    localparam int c_NB   = WORD_WIDTH / 8;
    localparam int c_IDXW = (c_NW > 1) ? $clog2(c_NW) : 1;
    localparam int c_BW   = $clog2(c_NB) + 1;

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_FILL  = 3'd1;
    localparam logic [2:0] c_ISSUE = 3'd2;
    localparam logic [2:0] c_BUSY  = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    logic [2:0]             r_state;
    logic [BLOCK_WIDTH-1:0] r_buf;
    logic [c_IDXW-1:0]      r_idx;
    logic [DATA_LENGTH-1:0] r_cnt;
    logic [BLOCK_WIDTH-1:0] r_block;
    logic [DATA_LENGTH-1:0] r_len;
    logic                   r_init;
    logic                   r_next;
    logic                   r_final;
    logic                   r_done;
    logic                   r_first;
    logic                   r_last_blk;
    logic                   r_hold;

    logic [WORD_WIDTH-1:0]  w_swapped;
    logic [WORD_WIDTH-1:0]  w_masked;
    logic [c_BW-1:0]        w_nbytes;
    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_close;

`ifdef PACKER_BYTE_SWAP_EN
    generate
        for (genvar gb = 0; gb < c_NB; gb++) begin : g_swap
            assign w_swapped[gb*8 +: 8] = bus.in_data[WORD_WIDTH-1-gb*8 -: 8];
        end
    endgenerate
`else
    assign w_swapped = bus.in_data;
`endif

    // Byte count of the accepted word: full width unless a last word says fewer.
    always_comb begin
        w_nbytes = c_BW'(c_NB);
        if (bus.in_last && (bus.in_bytes < c_BW'(c_NB))) begin
            w_nbytes = bus.in_bytes;
        end
    end

    generate
        for (genvar gb = 0; gb < c_NB; gb++) begin : g_mask
            assign w_masked[gb*8 +: 8] = (c_BW'(gb) < w_nbytes) ? w_swapped[gb*8 +: 8] : 8'h00;
        end
    endgenerate

    assign w_in_ready = (r_state == c_FILL) && !reset;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_close    = bus.in_last || (r_idx == c_IDXW'(c_NW - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_buf      <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_block    <= '0;
            r_len      <= '0;
            r_init     <= 1'b0;
            r_next     <= 1'b0;
            r_final    <= 1'b0;
            r_done     <= 1'b0;
            r_first    <= 1'b1;
            r_last_blk <= 1'b0;
            r_hold     <= 1'b0;
        end else begin
            r_init  <= 1'b0;
            r_next  <= 1'b0;
            r_final <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                c_IDLE: r_state <= c_FILL;
                c_FILL: begin
                    if (w_accept) begin
                        r_buf[r_idx*WORD_WIDTH +: WORD_WIDTH] <= w_masked;
                        r_idx <= r_idx + c_IDXW'(1);
                        r_cnt <= r_cnt + DATA_LENGTH'(w_nbytes);
                        if (w_close) begin
                            r_last_blk <= bus.in_last;
                            r_state    <= c_ISSUE;
                        end
                    end
                end
                c_ISSUE: begin
                    if (bus.hash_ready) begin
                        r_block <= r_buf;
                        r_len   <= r_cnt;
                        if (r_last_blk) begin
                            r_final <= 1'b1;
                        end else if (r_first) begin
                            r_init <= 1'b1;
                        end else begin
                            r_next <= 1'b1;
                        end
                        r_first <= 1'b0;
                        r_buf   <= '0;
                        r_idx   <= '0;
                        r_hold  <= 1'b1;
                        r_state <= c_BUSY;
                    end
                end
                c_BUSY: begin
                    // hash_ready still reflects the pre-command engine for one cycle
                    if (r_hold) begin
                        r_hold <= 1'b0;
                    end else if (bus.hash_ready) begin
                        r_state <= r_last_blk ? c_DONE : c_FILL;
                    end
                end
                c_DONE: begin
                    if (bus.digest_valid) begin
                        r_done     <= 1'b1;
                        r_cnt      <= '0;
                        r_first    <= 1'b1;
                        r_last_blk <= 1'b0;
                        r_state    <= c_FILL;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.init        = r_init;
    assign bus.next        = r_next;
    assign bus.final_cmd   = r_final;
    assign bus.block_out   = r_block;
    assign bus.data_length = r_len;
    assign bus.msg_done    = r_done;
endmodule
`default_nettype wire
